// File: rtl/apb_clk_cfg_pkg.sv
// Shared decode constants, FSM states and STATUS layout for the clock-config APB bridge.
// Pure definitions: no latency, no flow control.
package apb_clk_cfg_pkg;

  localparam logic [3:0] CFG_SOC_BASE = 4'h0;
  localparam logic [3:0] CFG_PER_BASE = 4'h4;
  localparam logic [3:0] REG_STATUS   = 4'h8;
  localparam logic [3:0] REG_CLR      = 4'h9;

  localparam int STAT_SOC_LOCK = 0;
  localparam int STAT_PER_LOCK = 1;
  localparam int STAT_TIMEOUT  = 2;

  localparam logic [31:0] RDATA_DEFAULT = 32'h0;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SOC_REQ = 2'd1,
    ST_PER_REQ = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Command presented to one generator config port while its req is high.
  typedef struct packed {
    logic [1:0]  add;
    logic [31:0] data;
    logic        wrn;
  } cfg_cmd_t;

  function automatic logic [31:0] status_word(input logic soc_lock,
                                              input logic per_lock,
                                              input logic tmo_flag);
    logic [31:0] w;
    w                = RDATA_DEFAULT;
    w[STAT_SOC_LOCK] = soc_lock;
    w[STAT_PER_LOCK] = per_lock;
    w[STAT_TIMEOUT]  = tmo_flag;
    return w;
  endfunction

endpackage

// File: rtl/apb_clk_cfg_if_if.sv
// APB bus bundle between CPU-side master and the clock-config bridge.
// Signal names keep the slave-side _i/_o orientation.
interface apb_clk_cfg_if_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] paddr_i;
  logic [31:0]               pwdata_i;
  logic                      pwrite_i;
  logic                      psel_i;
  logic                      penable_i;
  logic [31:0]               prdata_o;
  logic                      pready_o;
  logic                      pslverr_o;

  modport master (
    output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_clk_cfg_if_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
// Output follows input after two clk_i edges; no flow control.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/apb_clk_cfg_if.sv
// APB slave bridging CPU accesses onto the clock generator's SoC/peripheral config handshakes.
// STATUS/CLR/unmapped complete with 0 waits; cfg accesses hold pready_o low until ack or timeout.
module apb_clk_cfg_if
  import apb_clk_cfg_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  apb_clk_cfg_if_if.slave       apb,

  input  logic                  soc_cfg_lock_i,
  output logic                  soc_cfg_req_o,
  input  logic                  soc_cfg_ack_i,
  output logic [1:0]            soc_cfg_add_o,
  output logic [31:0]           soc_cfg_data_o,
  input  logic [31:0]           soc_cfg_r_data_i,
  output logic                  soc_cfg_wrn_o,

  input  logic                  per_cfg_lock_i,
  output logic                  per_cfg_req_o,
  input  logic                  per_cfg_ack_i,
  output logic [1:0]            per_cfg_add_o,
  output logic [31:0]           per_cfg_data_o,
  input  logic [31:0]           per_cfg_r_data_i,
  output logic                  per_cfg_wrn_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 err_d, err_q;
  logic                 sticky_d, sticky_q;
  logic [31:0]          rdata_d, rdata_q;
  logic                 soc_req_d, soc_req_q;
  logic                 per_req_d, per_req_q;
  cfg_cmd_t             soc_cmd_d, soc_cmd_q;
  cfg_cmd_t             per_cmd_d, per_cmd_q;

  logic                 soc_lock_sync;
  logic                 per_lock_sync;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [3:0]           idx;
  logic                 access;
  logic                 tgt_ack;
  logic [31:0]          tgt_rdata;
  logic                 unused_paddr;

  logic                 pready;
  logic                 pslverr;
  logic [31:0]          prdata;
  cfg_cmd_t             new_cmd;

  sync_2ff u_sync_soc_lock (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (soc_cfg_lock_i),
    .q_o    (soc_lock_sync)
  );

  sync_2ff u_sync_per_lock (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (per_cfg_lock_i),
    .q_o    (per_lock_sync)
  );

  assign paddr        = apb.paddr_i;
  assign idx          = paddr[5:2];
  assign unused_paddr = ^{paddr[APB_ADDR_WIDTH-1:6], paddr[1:0]};
  assign access       = apb.psel_i & apb.penable_i;

  // Only the target of the in-flight request is listened to.
  assign tgt_ack   = (state_q == ST_SOC_REQ) ? soc_cfg_ack_i    : per_cfg_ack_i;
  assign tgt_rdata = (state_q == ST_SOC_REQ) ? soc_cfg_r_data_i : per_cfg_r_data_i;

  always_comb begin
    new_cmd      = '0;
    new_cmd.data = apb.pwdata_i;
    new_cmd.wrn  = ~apb.pwrite_i;
    if (idx < CFG_PER_BASE) begin
      new_cmd.add = 2'(idx - CFG_SOC_BASE);
    end else begin
      new_cmd.add = 2'(idx - CFG_PER_BASE);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    sticky_d  = sticky_q;
    rdata_d   = rdata_q;
    soc_req_d = soc_req_q;
    per_req_d = per_req_q;
    soc_cmd_d = soc_cmd_q;
    per_cmd_d = per_cmd_q;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = RDATA_DEFAULT;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (idx < REG_STATUS) begin
            cnt_d = '0;
            if (idx < CFG_PER_BASE) begin
              soc_cmd_d = new_cmd;
              soc_req_d = 1'b1;
              state_d   = ST_SOC_REQ;
            end else begin
              per_cmd_d = new_cmd;
              per_req_d = 1'b1;
              state_d   = ST_PER_REQ;
            end
          end else begin
            pready = 1'b1;
            if (idx == REG_STATUS) begin
              prdata = status_word(soc_lock_sync, per_lock_sync, sticky_q);
            end else if (idx == REG_CLR) begin
              if (apb.pwrite_i) begin
                sticky_d = 1'b0;
              end
            end else begin
              pslverr = 1'b1;
            end
          end
        end
      end

      ST_SOC_REQ, ST_PER_REQ: begin
        // Ack on the final counted cycle wins over the timeout.
        if (tgt_ack) begin
          if (state_q == ST_SOC_REQ) begin
            rdata_d = soc_cmd_q.wrn ? tgt_rdata : RDATA_DEFAULT;
          end else begin
            rdata_d = per_cmd_q.wrn ? tgt_rdata : RDATA_DEFAULT;
          end
          soc_req_d = 1'b0;
          per_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = RDATA_DEFAULT;
          err_d     = 1'b1;
          sticky_d  = 1'b1;
          soc_req_d = 1'b0;
          per_req_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        pready  = 1'b1;
        pslverr = err_q;
        prdata  = rdata_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        soc_req_d = 1'b0;
        per_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      rdata_q   <= RDATA_DEFAULT;
      soc_req_q <= 1'b0;
      per_req_q <= 1'b0;
      soc_cmd_q <= '0;
      per_cmd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      rdata_q   <= rdata_d;
      soc_req_q <= soc_req_d;
      per_req_q <= per_req_d;
      soc_cmd_q <= soc_cmd_d;
      per_cmd_q <= per_cmd_d;
    end
  end

  assign apb.pready_o  = pready;
  assign apb.pslverr_o = pslverr;
  assign apb.prdata_o  = prdata;

  assign soc_cfg_req_o  = soc_req_q;
  assign soc_cfg_add_o  = soc_cmd_q.add;
  assign soc_cfg_data_o = soc_cmd_q.data;
  assign soc_cfg_wrn_o  = soc_cmd_q.wrn;

  assign per_cfg_req_o  = per_req_q;
  assign per_cfg_add_o  = per_cmd_q.add;
  assign per_cfg_data_o = per_cmd_q.data;
  assign per_cfg_wrn_o  = per_cmd_q.wrn;

endmodule

// File: tb/tb_apb_clk_cfg_if.sv
// Self-checking bench for apb_clk_cfg_if: directed literal cases plus randomized APB traffic
// against a transaction-level model of wait states, errors, read data and request durations.
module tb_apb_clk_cfg_if;

  localparam int TO    = 16;
  localparam int NEVER = 99;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  apb_clk_cfg_if_if #(.APB_ADDR_WIDTH(12)) apb ();

  logic        soc_cfg_lock_i, soc_cfg_req_o, soc_cfg_ack_i, soc_cfg_wrn_o;
  logic [1:0]  soc_cfg_add_o;
  logic [31:0] soc_cfg_data_o, soc_cfg_r_data_i;
  logic        per_cfg_lock_i, per_cfg_req_o, per_cfg_ack_i, per_cfg_wrn_o;
  logic [1:0]  per_cfg_add_o;
  logic [31:0] per_cfg_data_o, per_cfg_r_data_i;

  apb_clk_cfg_if #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .apb              (apb.slave),
    .soc_cfg_lock_i   (soc_cfg_lock_i),
    .soc_cfg_req_o    (soc_cfg_req_o),
    .soc_cfg_ack_i    (soc_cfg_ack_i),
    .soc_cfg_add_o    (soc_cfg_add_o),
    .soc_cfg_data_o   (soc_cfg_data_o),
    .soc_cfg_r_data_i (soc_cfg_r_data_i),
    .soc_cfg_wrn_o    (soc_cfg_wrn_o),
    .per_cfg_lock_i   (per_cfg_lock_i),
    .per_cfg_req_o    (per_cfg_req_o),
    .per_cfg_ack_i    (per_cfg_ack_i),
    .per_cfg_add_o    (per_cfg_add_o),
    .per_cfg_data_o   (per_cfg_data_o),
    .per_cfg_r_data_i (per_cfg_r_data_i),
    .per_cfg_wrn_o    (per_cfg_wrn_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Responder knobs: ack rises once req has been high for more than *_dly cycles.
  int soc_dly, per_dly;
  bit per_tie;
  int soc_hi, per_hi, soc_tot, per_tot;

  // Model state: what the in-flight request should look like, and the visible STATUS bits.
  int          exp_tgt;
  logic [1:0]  exp_add;
  logic [31:0] exp_data;
  logic        exp_wrn;
  bit          m_sticky, m_soc, m_per;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk_i);
      soc_hi = (soc_cfg_req_o === 1'b1) ? soc_hi + 1 : 0;
      per_hi = (per_cfg_req_o === 1'b1) ? per_hi + 1 : 0;
      if (soc_cfg_req_o === 1'b1) soc_tot++;
      if (per_cfg_req_o === 1'b1) per_tot++;
      soc_cfg_ack_i = (soc_cfg_req_o === 1'b1) && (soc_hi > soc_dly);
      per_cfg_ack_i = per_tie || ((per_cfg_req_o === 1'b1) && (per_hi > per_dly));
      if (rst_ni) begin
        chk("req_exclusive", 32'(soc_cfg_req_o & per_cfg_req_o), 32'd0);
        if (soc_cfg_req_o === 1'b1) begin
          chk("soc_req_target", exp_tgt, 1);
          chk("soc_add", 32'(soc_cfg_add_o), 32'(exp_add));
          chk("soc_data", soc_cfg_data_o, exp_data);
          chk("soc_wrn", 32'(soc_cfg_wrn_o), 32'(exp_wrn));
        end
        if (per_cfg_req_o === 1'b1) begin
          chk("per_req_target", exp_tgt, 2);
          chk("per_add", 32'(per_cfg_add_o), 32'(exp_add));
          chk("per_data", per_cfg_data_o, exp_data);
          chk("per_wrn", 32'(per_cfg_wrn_o), 32'(exp_wrn));
        end
      end
    end
  endtask

  task automatic apb_xfer(input logic [11:0] addr, input bit wr, input logic [31:0] wd,
                          output logic [31:0] rd, output bit err, output int waits,
                          output bit tmo);
    @(posedge clk_i); #1;
    apb.paddr_i   = addr;
    apb.pwrite_i  = wr;
    apb.pwdata_i  = wd;
    apb.psel_i    = 1'b1;
    apb.penable_i = 1'b0;
    @(posedge clk_i); #1;
    apb.penable_i = 1'b1;
    waits = 0;
    tmo   = 1'b1;
    rd    = '0;
    err   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (apb.pready_o === 1'b1) begin
        rd  = apb.prdata_o;
        err = apb.pslverr_o;
        tmo = 1'b0;
        break;
      end
      waits++;
    end
    @(posedge clk_i); #1;
    apb.psel_i    = 1'b0;
    apb.penable_i = 1'b0;
  endtask

  task automatic do_xfer(input logic [11:0] addr, input bit wr, input logic [31:0] wd,
                         output logic [31:0] rd, output bit err, output int waits,
                         output int nreq);
    logic [3:0]  idx;
    logic [31:0] e_rd;
    int          d, e_req, e_waits, s0, p0;
    bit          e_err, chk_rd, tmo;
    idx    = addr[5:2];
    chk_rd = 1'b1;
    if (idx < 4'd8) begin
      d        = (idx < 4'd4) ? soc_dly : (per_tie ? 0 : per_dly);
      e_err    = (d >= TO);
      e_req    = e_err ? TO : d + 1;
      e_waits  = e_req + 1;
      e_rd     = (!wr && !e_err) ? ((idx < 4'd4) ? soc_cfg_r_data_i : per_cfg_r_data_i) : 32'h0;
      exp_tgt  = (idx < 4'd4) ? 1 : 2;
      exp_add  = idx[1:0];
      exp_data = wd;
      exp_wrn  = ~wr;
    end else begin
      e_req   = 0;
      e_waits = 0;
      e_err   = (idx > 4'd9);
      e_rd    = (idx == 4'd8) ? {29'b0, m_sticky, m_per, m_soc} : 32'h0;
      chk_rd  = !(idx == 4'd8 && wr);
      exp_tgt = 0;
    end
    s0 = soc_tot;
    p0 = per_tot;
    apb_xfer(addr, wr, wd, rd, err, waits, tmo);
    nreq = (soc_tot - s0) + (per_tot - p0);
    chk("pready_seen", 32'(tmo), 32'd0);
    chk("wait_states", waits, e_waits);
    chk("pslverr", 32'(err), 32'(e_err));
    if (chk_rd) chk("prdata", rd, e_rd);
    chk("soc_req_cycles", soc_tot - s0, (exp_tgt == 1) ? e_req : 0);
    chk("per_req_cycles", per_tot - p0, (exp_tgt == 2) ? e_req : 0);
    if (e_err && idx < 4'd8) m_sticky = 1'b1;
    if (idx == 4'd9 && wr) m_sticky = 1'b0;
  endtask

  task automatic set_locks(input bit s, input bit p);
    soc_cfg_lock_i = s;
    per_cfg_lock_i = p;
    repeat (4) @(posedge clk_i);
    #1;
    m_soc = s;
    m_per = p;
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] rd;
    bit          err;
    int          w, nr;

    apb.paddr_i = '0; apb.pwdata_i = '0; apb.pwrite_i = 1'b0;
    apb.psel_i  = 1'b0; apb.penable_i = 1'b0;
    soc_cfg_lock_i = 1'b1; per_cfg_lock_i = 1'b1;
    soc_cfg_ack_i = 1'b0; per_cfg_ack_i = 1'b0;
    soc_cfg_r_data_i = '0; per_cfg_r_data_i = '0;
    soc_dly = 0; per_dly = 0; per_tie = 1'b0;
    soc_hi = 0; per_hi = 0; soc_tot = 0; per_tot = 0;
    exp_tgt = 0; exp_add = '0; exp_data = '0; exp_wrn = 1'b0;
    m_sticky = 1'b0; m_soc = 1'b1; m_per = 1'b1;
    fork
      monitor();
    join_none

    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_pready", 32'(apb.pready_o), 32'd0);
    chk("rst_pslverr", 32'(apb.pslverr_o), 32'd0);
    chk("rst_prdata", apb.prdata_o, 32'h0);
    chk("rst_soc_req", 32'(soc_cfg_req_o), 32'd0);
    chk("rst_per_req", 32'(per_cfg_req_o), 32'd0);
    chk("rst_soc_cmd", {soc_cfg_data_o[29:0], soc_cfg_add_o}, 32'h0);
    chk("rst_soc_wrn", 32'(soc_cfg_wrn_o), 32'd0);
    chk("rst_per_cmd", {per_cfg_data_o[29:0], per_cfg_add_o}, 32'h0);
    chk("rst_per_wrn", 32'(per_cfg_wrn_o), 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);

    // STATUS with both locks settled high
    do_xfer(12'h020, 1'b0, 32'h0, rd, err, w, nr);
    chk("lit_status_rd", rd, 32'h3);
    chk("lit_status_waits", w, 0);
    chk("lit_status_err", 32'(err), 32'd0);

    // Write to per reg 1 with ack tied high
    per_tie = 1'b1;
    do_xfer(12'h014, 1'b1, 32'hCAFE0001, rd, err, w, nr);
    per_tie = 1'b0;
    chk("lit_per_wr_waits", w, 2);
    chk("lit_per_wr_reqs", nr, 1);
    chk("lit_per_add", 32'(per_cfg_add_o), 32'd1);
    chk("lit_per_data", per_cfg_data_o, 32'hCAFE0001);
    chk("lit_per_wrn", 32'(per_cfg_wrn_o), 32'd0);

    // Read SoC reg 2 with ack five cycles late
    soc_dly = 5;
    soc_cfg_r_data_i = 32'hDEADDA7A;
    do_xfer(12'h008, 1'b0, 32'h0, rd, err, w, nr);
    chk("lit_soc_rd_data", rd, 32'hDEADDA7A);
    chk("lit_soc_rd_reqs", nr, 6);
    chk("lit_soc_rd_err", 32'(err), 32'd0);
    chk("lit_soc_wrn", 32'(soc_cfg_wrn_o), 32'd1);

    // Ack in the very cycle the timeout expires still succeeds
    soc_dly = TO - 1;
    soc_cfg_r_data_i = 32'h0BADF00D;
    do_xfer(12'h00C, 1'b0, 32'h0, rd, err, w, nr);
    chk("lit_edge_err", 32'(err), 32'd0);
    chk("lit_edge_reqs", nr, TO);
    chk("lit_edge_data", rd, 32'h0BADF00D);

    // No ack at all: timeout, sticky flag, then clear
    soc_dly = NEVER;
    do_xfer(12'h004, 1'b0, 32'h0, rd, err, w, nr);
    chk("lit_tmo_reqs", nr, 16);
    chk("lit_tmo_err", 32'(err), 32'd1);
    chk("lit_tmo_data", rd, 32'h0);
    do_xfer(12'h020, 1'b0, 32'h0, rd, err, w, nr);
    chk("lit_sticky_set", rd, 32'h7);
    do_xfer(12'h024, 1'b1, 32'h0, rd, err, w, nr);
    do_xfer(12'h020, 1'b0, 32'h0, rd, err, w, nr);
    chk("lit_sticky_clr", rd, 32'h3);

    // Unmapped register
    do_xfer(12'h02C, 1'b0, 32'h0, rd, err, w, nr);
    chk("lit_unmapped_waits", w, 0);
    chk("lit_unmapped_err", 32'(err), 32'd1);
    chk("lit_unmapped_reqs", nr, 0);

    // Reset while a request is pending
    soc_dly  = NEVER;
    exp_tgt  = 1; exp_add = 2'd1; exp_data = 32'h12345678; exp_wrn = 1'b0;
    @(posedge clk_i); #1;
    apb.paddr_i = 12'h004; apb.pwrite_i = 1'b1; apb.pwdata_i = 32'h12345678;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0;
    @(posedge clk_i); #1 apb.penable_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #2;
    chk("rst_mid_req_before", 32'(soc_cfg_req_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_req_async", 32'(soc_cfg_req_o), 32'd0);
    chk("rst_mid_pready", 32'(apb.pready_o), 32'd0);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    exp_tgt = 0;
    m_sticky = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    soc_dly = 0;
    soc_cfg_r_data_i = 32'h5A5A1234;
    do_xfer(12'h000, 1'b0, 32'h0, rd, err, w, nr);
    chk("lit_post_rst_waits", w, 2);
    chk("lit_post_rst_data", rd, 32'h5A5A1234);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) set_locks(1'($urandom), 1'($urandom));
      soc_dly = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 17));
      per_dly = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 17));
      soc_cfg_r_data_i = $urandom;
      per_cfg_r_data_i = $urandom;
      a = {6'($urandom), 4'($urandom), 2'($urandom)};
      do_xfer(a, 1'($urandom), $urandom, rd, err, w, nr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_clk_cfg_if.md
Name: apb_clk_cfg_if

Overview:
- APB slave that bridges CPU accesses to the FPGA clock generator's SoC and peripheral configuration ports.
- Converts APB reads/writes into the generator's req/ack/add/data/wrn handshake.
- Synchronises and exposes the lock flags; bounds every handshake with a timeout.
- Sits in the SoC peripheral subsystem, directly upstream of the clock generator.

Parameters:
- APB_ADDR_WIDTH, 12, width of paddr_i; only bits [5:2] are decoded.
- TIMEOUT_CYCLES, 256, clk_i cycles to wait for ack before aborting with error; legal range 2..65535.

Ports:
- clk_i  in  1  system clock (single clock domain).
- rst_ni  in  1  asynchronous active-low reset.
- paddr_i  in  APB_ADDR_WIDTH  APB address.
- pwdata_i  in  32  APB write data.
- pwrite_i  in  1  APB write.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- prdata_o  out  32  APB read data.
- pready_o  out  1  APB ready.
- pslverr_o  out  1  APB error.
- soc_cfg_lock_i  in  1  SoC clock lock, asynchronous.
- soc_cfg_req_o  out  1  SoC config request.
- soc_cfg_ack_i  in  1  SoC config acknowledge.
- soc_cfg_add_o  out  2  SoC config register index.
- soc_cfg_data_o  out  32  SoC config write data.
- soc_cfg_r_data_i  in  32  SoC config read data.
- soc_cfg_wrn_o  out  1  0 = write, 1 = read.
- per_cfg_lock_i, per_cfg_req_o, per_cfg_ack_i, per_cfg_add_o, per_cfg_data_o, per_cfg_r_data_i, per_cfg_wrn_o: identical set for the peripheral clock.

Behaviour:
- Reset (async, rst_ni=0):
  - FSM to IDLE.
  - All req_o, pready_o, pslverr_o = 0; prdata_o = 0; add/data/wrn outputs = 0.
  - Timeout counter = 0; lock synchronisers = 0.
- Address map (paddr_i[5:2]):
  - 0x0–0x3: SoC cfg reg 0–3.
  - 0x4–0x7: per cfg reg 0–3.
  - 0x8 STATUS, read-only: bit0 soc lock (synced), bit1 per lock (synced), bit2 sticky timeout flag; other bits 0.
  - 0x9 CLR: any write clears the sticky flag; reads return 0.
  - Anything else is unmapped.
- Lock inputs pass through a 2-flop synchroniser before use.
- FSM states IDLE, SOC_REQ, PER_REQ, RESP.
- IDLE:
  - Access phase (psel_i & penable_i) to STATUS, CLR or unmapped completes combinationally, zero wait states: pready_o=1.
  - Unmapped accesses additionally drive pslverr_o=1 and prdata_o=0.
  - Access phase to a cfg register: pready_o=0. Register add=paddr_i[3:2], data=pwdata_i, wrn=~pwrite_i.
  - Next state is SOC_REQ or PER_REQ; req_o rises on the following edge (registered).
- SOC_REQ / PER_REQ:
  - Matching req_o=1; add/data/wrn held stable.
  - Counter increments each cycle.
  - When ack_i=1 is sampled: capture r_data_i (reads only), drop req_o on the same edge, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: drop req_o, set sticky flag, mark error, go to RESP.
- RESP:
  - One cycle with pready_o=1, pslverr_o = error mark, prdata_o = captured data for reads (0 for writes, 0 on timeout).
  - Clear counter and error mark, return to IDLE.
- Latency with ack tied high:
  - Access-phase cycle T0 is IDLE; req high at T1, ack sampled at T1; RESP at T2.
  - Result: pready_o high in the 3rd access-phase cycle, i.e. 2 wait states.
- Ack arriving in the same cycle as timeout expiry counts as success: no error, sticky flag unchanged.
- psel_i dropping mid-transaction is a protocol violation; the FSM still completes its sequence with no corruption.
- Requests to the two targets are never concurrent: only one req_o is high at a time.
- prdata_o is registered in RESP; combinational only in IDLE for STATUS.

Decomposition:
- Package apb_clk_cfg_pkg:
  - Register index constants (CFG_SOC_BASE, CFG_PER_BASE, REG_STATUS, REG_CLR).
  - FSM state enum.
  - STATUS bit positions.
  - The 32'h0 default read constant.
- Sub-module sync_2ff: lock-input synchroniser, instantiated twice.

Test Plan:
- Reset, then read STATUS with both locks held 1 for more than 3 cycles → prdata_o=32'h3, 0 wait states, pslverr_o=0.
- Write 32'hCAFE0001 to 0x14 with per ack tied 1:
  - per_cfg_req_o high exactly 1 cycle, per_cfg_add_o=2'd1, per_cfg_data_o=32'hCAFE0001, per_cfg_wrn_o=0.
  - pready_o after 2 wait states.
- Read 0x08 with soc_cfg_r_data_i=32'hDEADDA7A and ack delayed 5 cycles:
  - soc_cfg_req_o high 6 cycles, soc_cfg_wrn_o=1.
  - prdata_o=32'hDEADDA7A, pslverr_o=0.
- Ack held 0 with TIMEOUT_CYCLES=16:
  - req high 16 cycles, then pslverr_o=1 and prdata_o=0.
  - STATUS bit2=1; write CLR → bit2=0.
- Assert rst_ni=0 while req is pending → req_o=0 immediately (async); next access behaves normally from IDLE.
- Access to unmapped 0x2C → pready_o=1 in the same cycle, pslverr_o=1, no req_o toggles.
